// File: rtl/buzzer_arbiter.sv
// Fixed-priority arbiter that drives the shared piezo buzzer for the keypad lock.
// It sequences the tone patterns for key click, accept and reject (beep-gap-beep).
module buzzer_arbiter #(
  parameter int unsigned KEY_HALF = 50000,
  parameter int unsigned KEY_LEN  = 10000000,
  parameter int unsigned OK_HALF  = 25000,
  parameter int unsigned OK_LEN   = 30000000,
  parameter int unsigned ERR_HALF = 100000,
  parameter int unsigned ERR_ON   = 5000000,
  parameter int unsigned ERR_GAP  = 5000000,
  parameter int unsigned CW       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_key,
  input  logic       req_ok,
  input  logic       req_err,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_src,
  output logic       done
);

  // state      | meaning
  // S_IDLE     | silent, waiting for a request
  // S_KEY      | key-click tone
  // S_OK       | accept tone
  // S_ERR_ON1  | first reject beep
  // S_ERR_GAP  | silent gap between reject beeps
  // S_ERR_ON2  | second reject beep
  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_OK, S_ERR_ON1, S_ERR_GAP, S_ERR_ON2
  } state_t;

  localparam logic [CW-1:0] KEY_HALF_M1 = CW'(KEY_HALF - 1);
  localparam logic [CW-1:0] KEY_LEN_M1  = CW'(KEY_LEN - 1);
  localparam logic [CW-1:0] OK_HALF_M1  = CW'(OK_HALF - 1);
  localparam logic [CW-1:0] OK_LEN_M1   = CW'(OK_LEN - 1);
  localparam logic [CW-1:0] ERR_HALF_M1 = CW'(ERR_HALF - 1);
  localparam logic [CW-1:0] ERR_ON_M1   = CW'(ERR_ON - 1);
  localparam logic [CW-1:0] ERR_GAP_M1  = CW'(ERR_GAP - 1);

  state_t        state, state_nx;
  logic [CW-1:0] dur_cnt, dur_nx;
  logic [CW-1:0] tone_cnt, tone_cnt_nx;
  logic          tone, tone_nx;
  logic          done_q, done_nx;
  logic [1:0]    src, src_nx;

  logic [CW-1:0] len_m1, half_m1;
  logic [1:0]    req_pri;
  logic          dur_end, pat_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dur_cnt  <= '0;
      tone_cnt <= '0;
      tone     <= 1'b0;
      done_q   <= 1'b0;
      src      <= 2'b00;
    end else begin
      state    <= state_nx;
      dur_cnt  <= dur_nx;
      tone_cnt <= tone_cnt_nx;
      tone     <= tone_nx;
      done_q   <= done_nx;
      src      <= src_nx;
    end
  end

  always_comb begin
    len_m1  = '0;
    half_m1 = '0;
    case (state)
      S_KEY:     begin len_m1 = KEY_LEN_M1; half_m1 = KEY_HALF_M1; end
      S_OK:      begin len_m1 = OK_LEN_M1;  half_m1 = OK_HALF_M1;  end
      S_ERR_ON1: begin len_m1 = ERR_ON_M1;  half_m1 = ERR_HALF_M1; end
      S_ERR_GAP: begin len_m1 = ERR_GAP_M1; half_m1 = ERR_HALF_M1; end
      S_ERR_ON2: begin len_m1 = ERR_ON_M1;  half_m1 = ERR_HALF_M1; end
      default:   begin len_m1 = '0;         half_m1 = '0;          end
    endcase
  end

  // src doubles as the priority of the running pattern (0 when idle).
  assign req_pri = req_err ? 2'd3 : (req_ok ? 2'd2 : (req_key ? 2'd1 : 2'd0));
  assign dur_end = (state != S_IDLE) && (dur_cnt == len_m1);
  assign pat_end = dur_end && (state == S_KEY || state == S_OK || state == S_ERR_ON2);

  always_comb begin
    state_nx    = state;
    dur_nx      = dur_cnt;
    tone_cnt_nx = tone_cnt;
    tone_nx     = tone;
    done_nx     = 1'b0;
    src_nx      = src;
    if (req_pri != 2'd0 && (req_pri >= src || pat_end)) begin
      case (req_pri)
        2'd3:    state_nx = S_ERR_ON1;
        2'd2:    state_nx = S_OK;
        default: state_nx = S_KEY;
      endcase
      dur_nx      = '0;
      tone_cnt_nx = '0;
      tone_nx     = 1'b1;
      src_nx      = req_pri;
    end else if (dur_end) begin
      dur_nx      = '0;
      tone_cnt_nx = '0;
      case (state)
        S_ERR_ON1: begin state_nx = S_ERR_GAP; tone_nx = 1'b0; end
        S_ERR_GAP: begin state_nx = S_ERR_ON2; tone_nx = 1'b1; end
        default: begin
          state_nx = S_IDLE;
          tone_nx  = 1'b0;
          src_nx   = 2'b00;
          done_nx  = 1'b1;
        end
      endcase
    end else if (state == S_ERR_GAP) begin
      dur_nx      = dur_cnt + 1'b1;
      tone_cnt_nx = '0;
      tone_nx     = 1'b0;
    end else if (state != S_IDLE) begin
      dur_nx = dur_cnt + 1'b1;
      if (tone_cnt == half_m1) begin
        tone_cnt_nx = '0;
        tone_nx     = ~tone;
      end else begin
        tone_cnt_nx = tone_cnt + 1'b1;
      end
    end
  end

  assign buzzer     = tone & ~mute;
  assign busy       = (state != S_IDLE);
  assign active_src = src;
  assign done       = done_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Scoreboard bench for buzzer_arbiter: a pattern-level reference model predicts every cycle,
// and a negedge monitor compares the DUT outputs against the queued predictions.
module tb_buzzer_arbiter;
  localparam int KH = 2, KL = 10, OH = 1, OL = 12, EH = 3, EON = 6, EGAP = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_key = 1'b0, req_ok = 1'b0, req_err = 1'b0, mute = 1'b0;
  logic       buzzer, busy, done;
  logic [1:0] active_src;

  buzzer_arbiter #(
    .KEY_HALF(KH), .KEY_LEN(KL), .OK_HALF(OH), .OK_LEN(OL),
    .ERR_HALF(EH), .ERR_ON(EON), .ERR_GAP(EGAP), .CW(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_key(req_key), .req_ok(req_ok), .req_err(req_err),
    .mute(mute), .buzzer(buzzer), .busy(busy), .active_src(active_src), .done(done)
  );

  always #5 clk = ~clk;

  logic [4:0] exp_q[$];
  int n_checks = 0, n_pass = 0, cyc = 0;

  // Model: which pattern is sounding (0 none, 1 key, 2 ok, 3 err) and cycles elapsed in it.
  int   m_kind = 0, m_t = 0;
  logic m_done = 1'b0;

  function automatic int total(input int k);
    case (k)
      1:       return KL;
      2:       return OL;
      default: return 2 * EON + EGAP;
    endcase
  endfunction

  function automatic logic wave(input int k, input int t);
    if (k == 1) return ((t / KH) % 2) == 0;
    if (k == 2) return ((t / OH) % 2) == 0;
    if (t < EON) return ((t / EH) % 2) == 0;
    if (t < EON + EGAP) return 1'b0;
    return (((t - EON - EGAP) / EH) % 2) == 0;
  endfunction

  task automatic model_edge();
    int   p;
    logic ending;
    p = req_err ? 3 : (req_ok ? 2 : (req_key ? 1 : 0));
    ending = (m_kind != 0) && (m_t == total(m_kind) - 1);
    if (p != 0 && (p >= m_kind || ending)) begin
      m_kind = p; m_t = 0; m_done = 1'b0;
    end else if (m_kind != 0) begin
      if (ending) begin
        m_kind = 0; m_t = 0; m_done = 1'b1;
      end else begin
        m_t++; m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
  endtask

  // Inputs given here are sampled at the following edge; m applies to the coming cycle.
  task automatic step(input logic k, input logic o, input logic e, input logic m, input logic r);
    logic snd;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    rst_n = r;
    if (!r) begin
      m_kind = 0; m_t = 0; m_done = 1'b0;
    end
    req_key = k; req_ok = o; req_err = e; mute = m;
    snd = (m_kind != 0) && wave(m_kind, m_t) && !m;
    exp_q.push_back({snd, m_kind != 0, 2'(m_kind), m_done});
  endtask

  task automatic idle(input int n, input logic m);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, m, 1'b1);
  endtask

  always @(negedge clk) begin
    logic [4:0] e, got;
    cyc++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {buzzer, busy, active_src, done};
      n_checks++;
      if (got === e) n_pass++;
      else $display("FAIL cycle %0d {buzzer,busy,src,done} got %b expected %b", cyc, got, e);
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    // key click
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); idle(13, 1'b0);
    // reject
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); idle(19, 1'b0);
    // simultaneous requests, then ok during the gap
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); idle(7, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); idle(12, 1'b0);
    // key preempted by ok, then ok restarted
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); idle(3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); idle(4, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); idle(14, 1'b0);
    // muted key click
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); idle(12, 1'b1); idle(2, 1'b0);
    // reset in the middle of ok, then a clean key click
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); idle(3, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); idle(13, 1'b0);
    // lower-priority key landing on the final edge of ok is still accepted
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); idle(11, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); idle(12, 1'b0);
    // key dropped while ok runs
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); idle(4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); idle(12, 1'b0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic k, o, e, m;
      k = ($urandom_range(0, 99) < 4);
      o = ($urandom_range(0, 99) < 3);
      e = ($urandom_range(0, 99) < 2);
      m = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 999) < 3) step(1'b0, 1'b0, 1'b0, m, 1'b0);
      else step(k, o, e, m, 1'b1);
    end
    idle(20, 1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
